serial_rx_sampler: RTL
======================

# serial_rx_sampler

Receive-side front end of the serial link: synchronises the asynchronous serial line, detects start bits, times bit centres with a 16x oversample counter and shifts in 8 data bits LSB first. It sits directly upstream of the bit identification counter. Its one-cycle `bitStrobe` drives that counter's `enable`, exactly 10 pulses per frame (start, 8 data, stop). It also presents the assembled character with a one-cycle valid pulse.

## Interface
- `OVERSAMPLE`, 16: clock cycles per bit time. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame.
- `clk`  input  1  oversample clock (OVERSAMPLE × baud).
- `rst`  input  1  reset, synchronous, active-high.
- `serialIn`  input  1  asynchronous serial line. Idle high.
- `bitStrobe`  output  1  one-cycle pulse at each sampled bit centre. Feeds downstream `enable`.
- `charOut`  output  DATA_BITS  last correctly framed character. Held until the next good frame.
- `charReady`  output  1  one-cycle pulse when `charOut` updates.
- `framingError`  output  1  one-cycle pulse when the stop bit samples low.
- `busy`  output  1  high while a frame is in progress.

## Operation
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Synchroniser: `serialIn` passes through two flops; the second flop output is `rxs`. Both flops reset to 1.
- Counters: `sampleCnt` is log2(OVERSAMPLE) bits wide; `bitCnt` is ⌈log2(DATA_BITS)⌉ bits wide.
- State machine states: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - If `rxs`==0: go to START and clear `sampleCnt`.
  - Otherwise stay in IDLE.
- START: `sampleCnt` increments each cycle. When `sampleCnt`==OVERSAMPLE/2−1:
  - If `rxs`==0: go to DATA, clear `sampleCnt` and `bitCnt`, and pulse `bitStrobe`.
  - If `rxs`==1: false start. Return to IDLE with no strobe.
- DATA: `sampleCnt` increments and wraps at OVERSAMPLE. When `sampleCnt`==OVERSAMPLE−1:
  - Shift `rxs` into the MSB of the shift register, shifting right.
  - Pulse `bitStrobe` and increment `bitCnt`.
  - If `bitCnt`==DATA_BITS−1: go to STOP and clear `sampleCnt`.
- STOP: when `sampleCnt`==OVERSAMPLE−1, pulse `bitStrobe`, then:
  - If `rxs`==1: load `charOut` from the shift register and pulse `charReady`.
  - If `rxs`==0: pulse `framingError` and leave `charOut` unchanged.
  - In both cases, go to IDLE.
- `busy` = state ≠ IDLE (registered, tracks state).
- Every frame that passes start validation yields exactly DATA_BITS+2 `bitStrobe` pulses. A false start yields zero.
- `charReady` and `framingError` are mutually exclusive. Either one coincides with the final `bitStrobe` pulse.
- `serialIn` activity during DATA/STOP outside sample points is ignored. There is no glitch filtering beyond the centre sample.

## Timing
- All outputs are registered.
- Reset values: `bitStrobe` 0, `charReady` 0, `framingError` 0, `charOut` 0x00, `busy` 0.
- `rst` mid-frame:
  - Next edge: state IDLE, counters cleared, shift register cleared, all pulses low.
  - `charOut` returns to 0x00. No partial character is emitted.
- Edge numbering: the start bit's falling edge is first registered at edge n. `rxs` is low from edge n+1, and IDLE detects it at edge n+2.
- Start validation is at edge n+2+OVERSAMPLE/2 = n+10 for the defaults. This samples the line as of n+8, the bit centre. `bitStrobe` is high in the cycle after that edge.
- Data bit k (0-based) is sampled at edge n+10+16(k+1).
- Stop bit is sampled at edge n+154. `charReady` or `framingError` is high in the following cycle.
- Back-to-back frames: IDLE is re-entered at n+155. A new start edge at n+160, the nominal next frame, is detected with no lost cycles. Half a bit time of slack absorbs early starts.
- A frame is always 10 bits at OVERSAMPLE cycles each, matching the downstream 10-count.

## Test plan
- Reset then idle line high for 200 cycles → all outputs 0, `busy` 0, no `bitStrobe`.
- Send 0x41 (frame 0,1,0,0,0,0,0,1,0,1, 16 cycles per bit) → 10 `bitStrobe` pulses spaced 16 cycles, first 10 cycles after the falling edge. `charOut`=0x41 and a 1-cycle `charReady` coincide with the 10th strobe.
- Low glitch of 4 cycles on an idle line → `busy` high for 8 cycles, then IDLE. No `bitStrobe`, `charReady` or `framingError`.
- Send 0x55 with stop bit forced low → 10 strobes, `framingError` pulses once, `charOut` keeps its prior value, `charReady` stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap beyond the stop bit → 20 strobes, `charReady` twice, `charOut` reads 0x00 then 0xFF.
- Assert `rst` for 1 cycle during data bit 4 of 0xA5 → outputs return to reset values the next cycle. No `charReady`. A following 0x3C frame is received correctly.

Source files
------------

// File: rtl/serial_rx_sampler_if.sv
// Signal bundle between the serial receive sampler and its line/consumer side.
// The sampler uses the master modport; the line driver and consumer use slave.
interface serial_rx_sampler_if #(
    parameter int unsigned DataBits = 8
);
    logic                serial_in;
    logic                bit_strobe;
    logic [DataBits-1:0] char_out;
    logic                char_ready;
    logic                framing_error;
    logic                busy;

    modport master (
        input  serial_in,
        output bit_strobe, char_out, char_ready, framing_error, busy
    );

    modport slave (
        output serial_in,
        input  bit_strobe, char_out, char_ready, framing_error, busy
    );
endinterface

// File: rtl/serial_rx_sampler.sv
// Serial receive front end: line synchroniser, start-bit validation, bit-centre timing with
// an oversample counter, LSB-first data capture and stop-bit framing check.
module serial_rx_sampler #(
    parameter int unsigned Oversample = 16,
    parameter int unsigned DataBits   = 8
) (
    input logic                 clk,
    input logic                 rst,
    serial_rx_sampler_if.master bus
);
    localparam int unsigned SampleW = $clog2(Oversample);
    localparam int unsigned BitW    = (DataBits > 1) ? $clog2(DataBits) : 1;

    localparam logic [SampleW-1:0] HalfLast = SampleW'(Oversample / 2 - 1);
    localparam logic [SampleW-1:0] FullLast = SampleW'(Oversample - 1);
    localparam logic [BitW-1:0]    LastBit  = BitW'(DataBits - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e              state_q, state_d;
    logic                sync_q;
    logic                rxs_q;
    logic [SampleW-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [DataBits-1:0] char_q, char_d;
    logic                strobe_q, strobe_d;
    logic                ready_q, ready_d;
    logic                ferr_q, ferr_d;
    logic                busy_q;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        char_d       = char_q;
        strobe_d     = 1'b0;
        ready_d      = 1'b0;
        ferr_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d      = StStart;
                    sample_cnt_d = '0;
                end
            end
            StStart: begin
                // Half a bit in: the line must still be low or this was a glitch.
                if (sample_cnt_q == HalfLast) begin
                    if (!rxs_q) begin
                        state_d      = StData;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        strobe_d     = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + SampleW'(1);
                end
            end
            StData: begin
                if (sample_cnt_q == FullLast) begin
                    sample_cnt_d = '0;
                    shift_d      = {rxs_q, shift_q[DataBits-1:1]};
                    strobe_d     = 1'b1;
                    bit_cnt_d    = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + SampleW'(1);
                end
            end
            StStop: begin
                if (sample_cnt_q == FullLast) begin
                    sample_cnt_d = '0;
                    strobe_d     = 1'b1;
                    state_d      = StIdle;
                    if (rxs_q) begin
                        char_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + SampleW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            char_q       <= '0;
            strobe_q     <= 1'b0;
            ready_q      <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= bus.serial_in;
            rxs_q        <= sync_q;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            char_q       <= char_d;
            strobe_q     <= strobe_d;
            ready_q      <= ready_d;
            ferr_q       <= ferr_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    assign bus.bit_strobe    = strobe_q;
    assign bus.char_out      = char_q;
    assign bus.char_ready    = ready_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = busy_q;
endmodule
